// File: rtl/serializer_tx.sv
// Byte-queue to serial-line transmitter: pops one byte per word and sends it LSB-first with a
// write strobe per bit. Define SERIALIZER_PARITY_EN to append an even-parity bit after bit 7.
module serializer_tx #(
    parameter int HIGH_CYCLES = 10,
    parameter int LOW_CYCLES  = 10,
    parameter int GAP_CYCLES  = 30
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] data_in,
    input  logic [3:0] len_in,
    output logic       dequeue_out,
    input  logic       status_in,
    output logic       data_out,
    output logic       write_out,
    output logic       busy_out
);

`ifdef SERIALIZER_PARITY_EN
    localparam int         SW       = 8;
    localparam logic [3:0] LAST_IDX = 4'd8;
`else
    localparam int         SW       = 7;
    localparam logic [3:0] LAST_IDX = 4'd7;
`endif

    localparam int M1   = (HIGH_CYCLES > LOW_CYCLES) ? HIGH_CYCLES : LOW_CYCLES;
    localparam int TMAX = (M1 > GAP_CYCLES) ? M1 : GAP_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);

    localparam logic [TW-1:0] HI_LAST  = TW'(HIGH_CYCLES - 1);
    localparam logic [TW-1:0] LO_LAST  = TW'(LOW_CYCLES - 1);
    localparam logic [TW-1:0] GAP_LAST = TW'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, BIT_HIGH, BIT_LOW, GAP} state_t;

    state_t        state, state_n;
    logic [TW-1:0] timer, timer_n;
    logic [3:0]    index, index_n;
    // Holds only the bits still to be sent; bit 0 goes out at the next advance.
    logic [SW-1:0] shreg, shreg_n;
    logic          data_n, write_n, deq_n;

    assign busy_out = (state != IDLE);

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            timer       <= '0;
            index       <= 4'd0;
            data_out    <= 1'b0;
            write_out   <= 1'b0;
            dequeue_out <= 1'b0;
        end else begin
            state       <= state_n;
            timer       <= timer_n;
            index       <= index_n;
            data_out    <= data_n;
            write_out   <= write_n;
            dequeue_out <= deq_n;
        end
    end

    always_ff @(posedge clock) begin
        shreg <= shreg_n;
    end

    always_comb begin
        state_n = state;
        timer_n = timer;
        index_n = index;
        shreg_n = shreg;
        data_n  = data_out;
        write_n = write_out;
        deq_n   = 1'b0;

        case (state)
            IDLE: begin
                timer_n = '0;
                data_n  = 1'b0;
                write_n = 1'b0;
                if (status_in && (len_in != 4'd0)) begin
                    state_n = BIT_HIGH;
                    index_n = 4'd0;
`ifdef SERIALIZER_PARITY_EN
                    shreg_n = {^data_in, data_in[7:1]};
`else
                    shreg_n = data_in[7:1];
`endif
                    data_n  = data_in[0];
                    write_n = 1'b1;
                    deq_n   = 1'b1;
                end
            end

            BIT_HIGH: begin
                if (timer == HI_LAST) begin
                    timer_n = '0;
                    write_n = 1'b0;
                    state_n = BIT_LOW;
                end else begin
                    timer_n = timer + TW'(1);
                end
            end

            BIT_LOW: begin
                if (timer == LO_LAST) begin
                    timer_n = '0;
                    if (index != LAST_IDX) begin
                        index_n = index + 4'd1;
                        data_n  = shreg[0];
                        shreg_n = shreg >> 1;
                        write_n = 1'b1;
                        state_n = BIT_HIGH;
                    end else begin
                        data_n  = 1'b0;
                        state_n = (GAP_CYCLES == 0) ? IDLE : GAP;
                    end
                end else begin
                    timer_n = timer + TW'(1);
                end
            end

            GAP: begin
                if (timer == GAP_LAST) begin
                    timer_n = '0;
                    state_n = IDLE;
                end else begin
                    timer_n = timer + TW'(1);
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule
